// File: rtl/floor_seek_comparator.sv
// ============================================================================
// Module   : floor_seek_comparator
// Brief    : Latches a requested target floor, compares the sensed floor
//            against it every cycle and sequences SEEK / SETTLE / ARRIVED,
//            issuing up/down motion commands while seeking.
// Options  : FLOOR_RANGE_CHECK_EN - when defined, targets above MAX_FLOOR are
//            rejected with a one-cycle err pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floor_seek_comparator #(
  parameter int WIDTH     = 2,
  parameter int MAX_FLOOR = 3,
  parameter int SETTLE    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cur_floor,
  input  logic [WIDTH-1:0] tgt_floor,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             abort,
  output logic             equal,
  output logic             lower,
  output logic             greater,
  output logic             dir_up,
  output logic             dir_down,
  output logic             busy,
  output logic             arrived
`ifdef FLOOR_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_seek    = 2'd1;
  localparam logic [1:0] c_st_settle  = 2'd2;
  localparam logic [1:0] c_st_arrived = 2'd3;

  // Counter value on the last required equal cycle inside SETTLE.
  localparam logic [3:0] c_settle_last = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  // Reject nonsensical parameter sets at elaboration time.
  if ((SETTLE < 0) || (SETTLE > 15) || (MAX_FLOOR < 0) ||
      (MAX_FLOOR > ((1 << WIDTH) - 1))) begin : g_bad_params
    $error("floor_seek_comparator: illegal parameter combination");
  end

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_tgt;
  logic             r_equal;
  logic             r_lower;
  logic             r_greater;
  logic             w_xfer;
  logic             w_accept;
  logic [WIDTH-1:0] w_tgt_next;

  assign w_xfer = tgt_valid && (r_state == c_st_idle);

`ifdef FLOOR_RANGE_CHECK_EN
  localparam logic [WIDTH:0] c_max_floor = (WIDTH + 1)'(MAX_FLOOR);

  logic w_range_bad;
  logic r_err;

  assign w_range_bad = ({1'b0, tgt_floor} > c_max_floor);
  assign w_accept    = w_xfer && !w_range_bad;
  assign err         = r_err;

  // One-cycle error pulse for an out-of-range transfer attempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_xfer && w_range_bad;
    end
  end
`else
  assign w_accept = w_xfer;
`endif

  // Value tgt_reg holds after this edge; comparing against it keeps the
  // flags aligned with the latched target from the very first SEEK cycle.
  assign w_tgt_next = w_accept ? tgt_floor : r_tgt;

  // Target latch: loads only on an accepted IDLE transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt <= '0;
    end else if (w_accept) begin
      r_tgt <= tgt_floor;
    end
  end

  // Registered magnitude compare of the sensed floor against the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_equal   <= 1'b0;
      r_lower   <= 1'b0;
      r_greater <= 1'b0;
    end else begin
      r_equal   <= (cur_floor == w_tgt_next);
      r_lower   <= (cur_floor <  w_tgt_next);
      r_greater <= (cur_floor >  w_tgt_next);
    end
  end

  // Seek sequencer with settle counter; abort wins over arrival progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state <= c_st_seek;
          end
        end
        c_st_seek: begin
          if (abort) begin
            r_state <= c_st_idle;
          end else if (r_equal) begin
            r_cnt <= 4'd0;
            if (SETTLE == 0) begin
              r_state <= c_st_arrived;
            end else begin
              r_state <= c_st_settle;
            end
          end
        end
        c_st_settle: begin
          if (abort) begin
            r_state <= c_st_idle;
          end else if (!r_equal) begin
            r_state <= c_st_seek;
            r_cnt   <= 4'd0;
          end else if (r_cnt == c_settle_last) begin
            r_state <= c_st_arrived;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign equal     = r_equal;
  assign lower     = r_lower;
  assign greater   = r_greater;
  assign tgt_ready = (r_state == c_st_idle);
  assign busy      = (r_state != c_st_idle);
  assign arrived   = (r_state == c_st_arrived);
  assign dir_up    = r_lower   && (r_state == c_st_seek);
  assign dir_down  = r_greater && (r_state == c_st_seek);

endmodule

`default_nettype wire
